// File: rtl/dma_peripheral_endpoint.sv
// DMA peripheral endpoint: device-side responder for DREQ/DACK bus cycles.
// Requests service when its FIFO can give (device-to-memory) or take
// (memory-to-device) a byte. It completes transfers on the rising edge of a
// DACK-qualified strobe, counts them, and stops on its own count or on EOP_N.
module dma_peripheral_endpoint #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              DACK,
    input  logic              IOR_N,
    input  logic              IOW_N,
    input  logic              EOP_N,
    input  logic [DATA_W-1:0] DB_IN,
    output logic              DREQ,
    output logic [DATA_W-1:0] DB_OUT,
    output logic              DB_OE,
    input  logic              cfg_start,
    input  logic              cfg_dir,
    input  logic              cfg_demand,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              loc_in_valid,
    output logic              loc_in_ready,
    input  logic [DATA_W-1:0] loc_in_data,
    output logic              loc_out_valid,
    input  logic              loc_out_ready,
    output logic [DATA_W-1:0] loc_out_data,
    output logic              busy,
    output logic              done,
    output logic              tc_seen,
    output logic              err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] FULL_OCC = OW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_REQ,
        S_XFER,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic              demand_q, demand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tc_q, tc_d;
    logic              err_q, err_d;
    logic              dreq_q, dreq_d;
    logic              done_q, done_d;
    logic              dack_q, ior_q, iow_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     occ_q, occ_d;

    logic              empty, full, active, eop;
    logic              rd_cpl, wr_cpl, cpl, last;
    logic              dma_push, dma_pop, loc_push, loc_pop, push, pop;
    logic              underflow, overflow, elig_now, elig_next;
    logic [DATA_W-1:0] push_data, head;
    logic [CNT_W-1:0]  cnt_after;

    // FIFO status, completion detection and push/pop arbitration
    always_comb begin
        empty     = (occ_q == '0);
        full      = (occ_q == FULL_OCC);
        active    = (state_q == S_ARMED) || (state_q == S_REQ) || (state_q == S_XFER);
        eop       = ~EOP_N && ((state_q == S_REQ) || (state_q == S_XFER));
        // A transfer completes on the strobe's rising edge; DACK is taken from
        // the registered copy so it may already have dropped this cycle.
        rd_cpl    = active && ~dir_q && dack_q && ~ior_q && IOR_N;
        wr_cpl    = active && dir_q && dack_q && ~iow_q && IOW_N;
        cpl       = rd_cpl || wr_cpl;
        dma_pop   = rd_cpl && ~empty;
        dma_push  = wr_cpl && ~full;
        underflow = rd_cpl && empty;
        overflow  = wr_cpl && full;
        // The bus side wins if both sides push (or pop) in the same cycle.
        loc_push  = loc_in_valid && ~full && ~dma_push;
        loc_pop   = loc_out_ready && ~empty && ~dma_pop;
        push      = dma_push || loc_push;
        pop       = dma_pop || loc_pop;
        push_data = dma_push ? wdata_q : loc_in_data;
        occ_d     = occ_q + OW'(push) - OW'(pop);
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        head      = empty ? '0 : mem_q[rd_ptr_q];
        elig_now  = dir_q ? ~full : ~empty;
        elig_next = dir_q ? (occ_d != FULL_OCC) : (occ_d != '0);
        cnt_after = (cpl && (cnt_q != '0)) ? (cnt_q - CNT_W'(1)) : cnt_q;
        last      = cpl && (cnt_after == '0);
    end

    // Next-state logic for the transfer FSM and its sticky flags
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        demand_d = demand_q;
        cnt_d    = cnt_after;
        tc_d     = tc_q || eop;
        err_d    = err_q || underflow || overflow;
        done_d   = 1'b0;
        dreq_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    if (cfg_count != '0) begin
                        dir_d    = cfg_dir;
                        demand_d = cfg_demand;
                        cnt_d    = cfg_count;
                        tc_d     = 1'b0;
                        err_d    = 1'b0;
                        state_d  = S_ARMED;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (last)          state_d = S_DONE;
                else if (elig_now) state_d = S_REQ;
            end
            S_REQ: begin
                if (last || eop)                 state_d = S_DONE;
                else if (DACK)                   state_d = S_XFER;
                else if (demand_q && ~elig_now)  state_d = S_ARMED;
            end
            S_XFER: begin
                if (last || eop) state_d = S_DONE;
                else if (cpl)    state_d = (demand_q && elig_next) ? S_XFER : S_ARMED;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d = done_d || (state_d == S_DONE);
        dreq_d = (state_d == S_REQ) || (state_d == S_XFER);
    end

    // Control state, bus-strobe history and FIFO pointers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            demand_q <= 1'b0;
            cnt_q    <= '0;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
            dreq_q   <= 1'b0;
            done_q   <= 1'b0;
            dack_q   <= 1'b0;
            ior_q    <= 1'b1;
            iow_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            demand_q <= demand_d;
            cnt_q    <= cnt_d;
            tc_q     <= tc_d;
            err_q    <= err_d;
            dreq_q   <= dreq_d;
            done_q   <= done_d;
            dack_q   <= DACK;
            ior_q    <= IOR_N;
            iow_q    <= IOW_N;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Data path: write-strobe capture and FIFO storage (no reset needed)
    always_ff @(posedge CLK) begin
        if (!IOW_N) wdata_q <= DB_IN;
        if (push)   mem_q[wr_ptr_q] <= push_data;
    end

    // Output drive
    always_comb begin
        DREQ          = dreq_q;
        DB_OE         = busy && ~dir_q && DACK && ~IOR_N;
        DB_OUT        = head;
        loc_out_data  = head;
        loc_in_ready  = ~full;
        loc_out_valid = ~empty;
        busy          = (state_q != S_IDLE);
        done          = done_q;
        tc_seen       = tc_q;
        err           = err_q;
    end

endmodule

// File: tb/tb_dma_peripheral_endpoint.sv
// Directed bench for dma_peripheral_endpoint: read/write bursts, EOP
// termination, overflow, asynchronous reset, zero-count and busy starts.
module tb_dma_peripheral_endpoint;

    logic       CLK = 1'b0;
    logic       RESET_N, DACK, IOR_N, IOW_N, EOP_N;
    logic [7:0] DB_IN, DB_OUT, loc_in_data, loc_out_data;
    logic       DREQ, DB_OE;
    logic       cfg_start, cfg_dir, cfg_demand;
    logic [15:0] cfg_count;
    logic       loc_in_valid, loc_in_ready, loc_out_valid, loc_out_ready;
    logic       busy, done, tc_seen, err;

    int checks = 0;
    int errors = 0;

    dma_peripheral_endpoint #(.DATA_W(8), .FIFO_DEPTH(8), .CNT_W(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .EOP_N(EOP_N), .DB_IN(DB_IN), .DREQ(DREQ), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
        .cfg_start(cfg_start), .cfg_dir(cfg_dir), .cfg_demand(cfg_demand),
        .cfg_count(cfg_count), .loc_in_valid(loc_in_valid), .loc_in_ready(loc_in_ready),
        .loc_in_data(loc_in_data), .loc_out_valid(loc_out_valid),
        .loc_out_ready(loc_out_ready), .loc_out_data(loc_out_data),
        .busy(busy), .done(done), .tc_seen(tc_seen), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic dir, input logic demand, input logic [15:0] count);
        cfg_start = 1'b1; cfg_dir = dir; cfg_demand = demand; cfg_count = count;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic loc_push(input logic [7:0] v);
        loc_in_valid = 1'b1; loc_in_data = v;
        tick();
        loc_in_valid = 1'b0;
    endtask

    task automatic drain_check(input string tag, input logic [7:0] v);
        check({tag, "_valid"}, 32'(loc_out_valid), 1);
        check({tag, "_data"}, 32'(loc_out_data), 32'(v));
        loc_out_ready = 1'b1;
        tick();
        loc_out_ready = 1'b0;
    endtask

    // IOR cycle under DACK; DACK falls together with the strobe's rising edge
    task automatic ior_cycle(input string tag, input logic [7:0] v);
        DACK = 1'b1;
        tick();
        IOR_N = 1'b0;
        #1;
        check({tag, "_oe_on"}, 32'(DB_OE), 1);
        check({tag, "_dbout"}, 32'(DB_OUT), 32'(v));
        tick();
        IOR_N = 1'b1; DACK = 1'b0;
        #1;
        check({tag, "_oe_off"}, 32'(DB_OE), 0);
        tick();
    endtask

    task automatic iow_cycle(input logic [7:0] v);
        DACK = 1'b1; DB_IN = v;
        tick();
        IOW_N = 1'b0;
        tick();
        IOW_N = 1'b1; DACK = 1'b0; DB_IN = 8'h00;
        tick();
    endtask

    initial begin
        RESET_N = 1'b0; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
        DB_IN = 8'h00; cfg_start = 1'b0; cfg_dir = 1'b0; cfg_demand = 1'b0;
        cfg_count = 16'd0; loc_in_valid = 1'b0; loc_in_data = 8'h00; loc_out_ready = 1'b0;
        repeat (2) tick();

        // Reset values
        check("rst_dreq", 32'(DREQ), 0);
        check("rst_oe", 32'(DB_OE), 0);
        check("rst_dbout", 32'(DB_OUT), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_tc", 32'(tc_seen), 0);
        check("rst_err", 32'(err), 0);
        check("rst_empty", 32'(loc_out_valid), 0);
        check("rst_inrdy", 32'(loc_in_ready), 1);
        RESET_N = 1'b1;
        tick();

        // Device-to-memory, single mode, three transfers
        start(1'b0, 1'b0, 16'd3);
        check("t1_busy", 32'(busy), 1);
        check("t1_armed_dreq", 32'(DREQ), 0);
        loc_push(8'hA1);
        loc_push(8'hB2);
        loc_push(8'hC3);
        check("t1_req", 32'(DREQ), 1);
        ior_cycle("t1_x1", 8'hA1);
        check("t1_gap1", 32'(DREQ), 0);
        check("t1_nodone1", 32'(done), 0);
        tick();
        check("t1_req2", 32'(DREQ), 1);
        ior_cycle("t1_x2", 8'hB2);
        check("t1_gap2", 32'(DREQ), 0);
        tick();
        check("t1_req3", 32'(DREQ), 1);
        ior_cycle("t1_x3", 8'hC3);
        check("t1_done", 32'(done), 1);
        check("t1_dreq_end", 32'(DREQ), 0);
        check("t1_tc", 32'(tc_seen), 0);
        check("t1_err", 32'(err), 0);
        tick();
        check("t1_done_once", 32'(done), 0);
        check("t1_idle", 32'(busy), 0);

        // Memory-to-device, demand mode, four transfers
        start(1'b1, 1'b1, 16'd4);
        tick();
        check("t2_req", 32'(DREQ), 1);
        iow_cycle(8'h11);
        check("t2_dreq1", 32'(DREQ), 1);
        iow_cycle(8'h22);
        check("t2_dreq2", 32'(DREQ), 1);
        iow_cycle(8'h33);
        check("t2_dreq3", 32'(DREQ), 1);
        check("t2_nodone", 32'(done), 0);
        iow_cycle(8'h44);
        check("t2_done", 32'(done), 1);
        check("t2_dreq_end", 32'(DREQ), 0);
        tick();
        check("t2_done_once", 32'(done), 0);
        drain_check("t2_o1", 8'h11);
        drain_check("t2_o2", 8'h22);
        drain_check("t2_o3", 8'h33);
        drain_check("t2_o4", 8'h44);
        check("t2_empty", 32'(loc_out_valid), 0);

        // EOP_N ends a count-5 read job after the second byte
        loc_push(8'h5A);
        loc_push(8'h6B);
        start(1'b0, 1'b0, 16'd5);
        tick();
        check("t3_req", 32'(DREQ), 1);
        ior_cycle("t3_x1", 8'h5A);
        tick();
        DACK = 1'b1;
        tick();
        IOR_N = 1'b0;
        #1;
        check("t3_x2_dbout", 32'(DB_OUT), 32'h6B);
        tick();
        IOR_N = 1'b1; DACK = 1'b0; EOP_N = 1'b0;
        tick();
        EOP_N = 1'b1;
        check("t3_done", 32'(done), 1);
        check("t3_tc", 32'(tc_seen), 1);
        check("t3_dreq", 32'(DREQ), 0);
        check("t3_popped", 32'(loc_out_valid), 0);
        check("t3_err", 32'(err), 0);
        tick();
        check("t3_idle", 32'(busy), 0);

        // Overflow: nine writes into an 8-deep FIFO with no local pops
        start(1'b1, 1'b1, 16'd9);
        check("t4_tc_clr", 32'(tc_seen), 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            iow_cycle(8'h80 + 8'(i));
            if (i < 7) check("t4_dreq_run", 32'(DREQ), 1);
        end
        check("t4_dreq_full", 32'(DREQ), 0);
        check("t4_full", 32'(loc_in_ready), 0);
        check("t4_err_pre", 32'(err), 0);
        tick();
        check("t4_dreq_hold", 32'(DREQ), 0);
        iow_cycle(8'hEE);
        check("t4_err", 32'(err), 1);
        check("t4_done", 32'(done), 1);
        tick();
        for (int i = 0; i < 8; i++) drain_check("t4_keep", 8'h80 + 8'(i));
        check("t4_empty", 32'(loc_out_valid), 0);
        check("t4_err_sticky", 32'(err), 1);

        // Asynchronous reset in the middle of an IOR strobe
        loc_push(8'h3C);
        start(1'b0, 1'b0, 16'd2);
        tick();
        DACK = 1'b1;
        tick();
        IOR_N = 1'b0;
        #1;
        check("t5_oe_pre", 32'(DB_OE), 1);
        check("t5_dreq_pre", 32'(DREQ), 1);
        RESET_N = 1'b0;
        #1;
        check("t5_dreq_async", 32'(DREQ), 0);
        check("t5_oe_async", 32'(DB_OE), 0);
        check("t5_busy_async", 32'(busy), 0);
        DACK = 1'b0; IOR_N = 1'b1;
        #1;
        RESET_N = 1'b1;
        tick();
        check("t5_empty", 32'(loc_out_valid), 0);
        check("t5_err", 32'(err), 0);

        // Zero count: done next cycle, no request
        start(1'b0, 1'b0, 16'd0);
        check("t6_zero_done", 32'(done), 1);
        check("t6_zero_busy", 32'(busy), 0);
        check("t6_zero_dreq", 32'(DREQ), 0);
        tick();
        check("t6_zero_done_once", 32'(done), 0);
        check("t6_zero_dreq2", 32'(DREQ), 0);

        // cfg_start while busy is ignored: count stays 2, direction stays read
        loc_push(8'h77);
        loc_push(8'h88);
        start(1'b0, 1'b0, 16'd2);
        cfg_start = 1'b1; cfg_dir = 1'b1; cfg_count = 16'd5;
        tick();
        cfg_start = 1'b0;
        check("t6_req", 32'(DREQ), 1);
        ior_cycle("t6_x1", 8'h77);
        check("t6_nodone", 32'(done), 0);
        tick();
        ior_cycle("t6_x2", 8'h88);
        check("t6_done", 32'(done), 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dma_peripheral_endpoint.md
Name: dma_peripheral_endpoint

Overview:
- Device-side responder for the DMA controller's bus cycles.
- Raises DREQ when it has data to give or room to take, answers DACK-qualified IOR_N/IOW_N strobes on the data bus, counts transfers, and terminates on its own count or on controller EOP_N.
- Sits between the DMA bus pins and a local streaming interface, with an internal FIFO.
- Used as the bench peer for the controller and as the template for real I/O devices.

Parameters:
- DATA_W, 8, data bus and FIFO width.
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, 16, transfer counter width.

Ports:
- CLK  in  1  system clock, shared with the DMA controller.
- RESET_N  in  1  asynchronous active-low reset.
- DACK  in  1  DMA acknowledge for this channel, active high.
- IOR_N  in  1  I/O read strobe; endpoint drives DB_OUT.
- IOW_N  in  1  I/O write strobe; endpoint captures DB_IN.
- EOP_N  in  1  end of process from the controller, active low.
- DB_IN  in  DATA_W  data bus, input side.
- DREQ  out  1  DMA request, active high.
- DB_OUT  out  DATA_W  data bus, output side.
- DB_OE  out  1  output enable for DB_OUT.
- cfg_start  in  1  one-cycle pulse; loads config and arms the block.
- cfg_dir  in  1  0 = device-to-memory (served by IOR); 1 = memory-to-device (served by IOW).
- cfg_demand  in  1  0 = single mode, 1 = demand mode.
- cfg_count  in  CNT_W  number of transfers to perform.
- loc_in_valid / loc_in_ready / loc_in_data  in/out/in  1/1/DATA_W  local push into FIFO; used when dir=0.
- loc_out_valid / loc_out_ready / loc_out_data  out/in/out  1/1/DATA_W  local pop from FIFO; used when dir=1.
- busy  out  1  armed or transferring.
- done  out  1  one-cycle pulse on termination.
- tc_seen  out  1  sticky; termination was caused by EOP_N.
- err  out  1  sticky; underflow or overflow occurred.

Behaviour:
- Reset values: DREQ=0, DB_OE=0, DB_OUT=0, busy=0, done=0, tc_seen=0, err=0, FIFO empty, counter=0, state IDLE. Reset is fully asynchronous, including mid-transfer.
- All bus inputs are synchronous to CLK. Registered copies dack_q, ior_q, iow_q are kept.
- Completion event: dack_q=1 and strobe_q=0 and strobe now 1 (rising edge of the strobe).
  - DACK may fall in the same cycle as the strobe rises; the transfer still counts.
- FSM states: IDLE, ARMED, REQ, XFER, DONE.
- IDLE:
  - cfg_start with cfg_count != 0: latch dir, demand and count; clear tc_seen and err; go to ARMED.
  - cfg_start with cfg_count == 0: pulse done and stay in IDLE.
- ARMED:
  - Go to REQ when eligible: dir=0 needs FIFO not empty; dir=1 needs FIFO not full.
  - DREQ rises in the cycle REQ is entered (registered).
- REQ:
  - DREQ=1.
  - DACK=1: go to XFER.
  - Demand mode: if eligibility is lost before DACK, DREQ drops and the FSM returns to ARMED.
  - Single mode: DREQ is held until DACK.
- XFER:
  - Read cycle (dir=0): DB_OE = DACK & ~IOR_N, combinational; DB_OUT = FIFO head.
  - On completion: pop the FIFO and decrement the counter.
  - Write cycle (dir=1): DB_IN is registered every cycle while IOW_N=0; on completion the last registered value is pushed and the counter decremented.
  - After completion:
    - Counter now 0: go to DONE.
    - Single mode: DREQ=0 for at least one cycle; go to ARMED.
    - Demand mode: DREQ stays high while still eligible; otherwise go to ARMED.
- EOP_N=0 sampled in REQ or XFER:
  - Set tc_seen and go to DONE next cycle.
  - A completion in the same cycle is performed and counted first.
- DONE: DREQ=0, pulse done for one cycle, go to IDLE. FIFO contents are retained; the local side drains or fills freely.
- busy=1 in ARMED, REQ, XFER and DONE.
- cfg_start while busy is ignored.
- Underflow: IOR completion with FIFO empty drives DB_OUT=0, does not pop, sets err; the counter still decrements.
- Overflow: IOW completion with FIFO full drops the data, sets err; the counter still decrements.
- Simultaneous local push and DMA pop, or DMA push and local pop, in one cycle: both happen; occupancy is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Occupancy is CLOG2(FIFO_DEPTH)+1 bits wide; full means occupancy = FIFO_DEPTH.
- loc_in_ready = ~full; loc_out_valid = ~empty.
- The local ports operate in every state.

Test Plan:
- dir=0, single mode, count=3; push A1,B2,C3; three IOR cycles under DACK → DB_OUT reads A1,B2,C3 with DB_OE only while IOR_N=0. DREQ drops between transfers. done pulses after the third completion; tc_seen=0, err=0.
- dir=1, demand mode, count=4; IOW cycles with 11,22,33,44 → DREQ stays high throughout; loc_out yields 11,22,33,44; done pulses once.
- dir=0, count=5, FIFO holds 2; EOP_N asserted low during the 2nd IOR strobe → 2nd byte completes, DONE follows, tc_seen=1, DREQ=0, 3 transfers remain uncounted.
- dir=1, FIFO_DEPTH=8, no local pops; 9 IOW cycles with count=9 → DREQ drops when full in demand mode. A forced 9th IOW cycle sets err=1, FIFO keeps the first 8 bytes, done pulses.
- RESET_N pulsed low mid-XFER with IOR_N=0 → DREQ, DB_OE and busy go to 0 immediately (asynchronously); FIFO is empty after release.
- cfg_start with count=0 → done pulses the next cycle and DREQ never rises. cfg_start while busy → no change to the count.
